// File: rtl/tttg_pkg.sv
// Shared types and constants for the tic-tac-toe game front end.
// Imported by the input controller and its debouncers.
package tttg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      DRIVE,
      RELEASE
   } state_t;

   localparam logic P1 = 1'b0;
   localparam logic P2 = 1'b1;

   localparam int N_CELLS = 9;

endpackage

// File: rtl/tttg_debounce.sv
// One board button: 2-flop synchronizer, saturating debounce counter,
// stable level and a one-cycle press pulse on a stable 0->1 change.
module tttg_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

   logic          sync1;
   logic          sync2;
   logic          stable;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         press <= 1'b0;
         // A full count of differing samples commits the new level.
         if (cnt == CNT_MAX) begin
            stable <= ~stable;
            cnt    <= '0;
            press  <= ~stable;
         end else if (sync2 == stable) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/tttg_input_ctrl.sv
// Board-button front end: debounces the nine cells, filters presses and
// plays the player-select / cell-select / release sequence to the core.
module tttg_input_ctrl
   import tttg_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLD_CYCLES     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] raw_btn,
   input  logic       new_game,
   output logic       play1,
   output logic       play2,
   output logic [8:0] button,
   output logic       turn,
   output logic       busy,
   output logic       reject
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   state_t              state;
   state_t              state_nxt;
   logic [HW-1:0]       hcnt;
   logic [N_CELLS-1:0]  ev;
   logic [N_CELLS-1:0]  sel;
   logic [N_CELLS-1:0]  occupied;
   logic                one_hot;
   logic                hit;
   logic                accept;
   logic                drive;

   for (genvar i = 0; i < N_CELLS; i++) begin : g_db
      tttg_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk  (clk),
         .reset(reset),
         .raw  (raw_btn[i]),
         .press(ev[i])
      );
   end

   assign one_hot = (ev != '0) && ((ev & (ev - 9'd1)) == '0);
   assign hit     = |(ev & occupied);
   assign accept  = (state == IDLE) && !new_game && one_hot && !hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = ARM;
         ARM:     state_nxt = DRIVE;
         DRIVE:   if (hcnt == HOLD_LAST) state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (new_game) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hcnt     <= '0;
         sel      <= '0;
         occupied <= '0;
         turn     <= P1;
         reject   <= 1'b0;
      end else begin
         hcnt <= (state == DRIVE) ? hcnt + HW'(1) : '0;
         // Events are never queued: anything not accepted is flagged.
         reject <= !new_game && (ev != '0) &&
                   ((state != IDLE) || !one_hot || hit);
         if (new_game) begin
            sel      <= '0;
            occupied <= '0;
            turn     <= P1;
         end else begin
            if (accept) sel <= ev;
            if (state == RELEASE) begin
               occupied <= occupied | sel;
               turn     <= ~turn;
            end
         end
      end
   end

   assign drive  = (state == ARM) || (state == DRIVE);
   assign play1  = drive && (turn == P1);
   assign play2  = drive && (turn == P2);
   assign button = (state == DRIVE) ? sel : '0;
   assign busy   = (state != IDLE);

endmodule

// File: tb/tb_tttg_input_ctrl.sv
// Bench for tttg_input_ctrl: directed scenarios plus random presses,
// every cycle compared against a window-based behavioural model.
module tb_tttg_input_ctrl;

   localparam int D = 16;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       new_game = 1'b0;
   logic [8:0] raw_btn = '0;
   logic       play1;
   logic       play2;
   logic [8:0] button;
   logic       turn;
   logic       busy;
   logic       reject;

   always #5 clk = ~clk;

   tttg_input_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES    (H)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .raw_btn (raw_btn),
      .new_game(new_game),
      .play1   (play1),
      .play2   (play2),
      .button  (button),
      .turn    (turn),
      .busy    (busy),
      .reject  (reject)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: raw history, per-cell stable level, game timeline.
   logic [8:0] hist[$];
   logic [8:0] m_stable;
   logic [8:0] m_ev;
   logic [8:0] m_occ;
   logic [8:0] m_sel;
   int         m_last[9];
   int         m_phase;
   logic       m_turn;
   logic       m_rej;

   logic saw_rej, saw_p1, saw_p2, prev_drv;
   logic [8:0] btn_or;
   int nplay;

   function automatic logic samp(int e, int i);
      if (e < 2) return 1'b0;
      return hist[e-2][i];
   endfunction

   task automatic model_reset();
      hist.delete();
      m_stable = '0;
      m_ev     = '0;
      m_occ    = '0;
      m_sel    = '0;
      m_phase  = 0;
      m_turn   = 1'b0;
      m_rej    = 1'b0;
      for (int i = 0; i < 9; i++) m_last[i] = -1;
   endtask

   task automatic model_edge(input logic ng);
      int n;
      logic [8:0] ev;
      n  = hist.size() - 1;
      ev = m_ev;
      m_rej = !ng && (ev != 0) &&
              (m_phase != 0 || $countones(ev) > 1 || (ev & m_occ) != 0);
      if (ng) begin
         m_phase = 0;
         m_occ   = '0;
         m_sel   = '0;
         m_turn  = 1'b0;
      end else if (m_phase == 0) begin
         if ($countones(ev) == 1 && (ev & m_occ) == 0) begin
            m_sel   = ev;
            m_phase = 1;
         end
      end else if (m_phase == H + 2) begin
         m_occ   = m_occ | m_sel;
         m_turn  = ~m_turn;
         m_phase = 0;
      end else begin
         m_phase++;
      end
      m_ev = '0;
      for (int i = 0; i < 9; i++) begin
         if (n - D >= m_last[i] + 1) begin
            bit all;
            all = 1'b1;
            for (int e = n - D; e < n; e++)
               if (samp(e, i) == m_stable[i]) all = 1'b0;
            if (all) begin
               m_stable[i] = ~m_stable[i];
               m_last[i]   = n;
               if (m_stable[i]) m_ev[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic tick();
      logic ng;
      logic drv;
      logic [8:0] e_btn;
      ng = new_game;
      hist.push_back(raw_btn);
      @(posedge clk);
      #1;
      model_edge(ng);
      drv   = (m_phase >= 1) && (m_phase <= H + 1);
      e_btn = (m_phase >= 2 && m_phase <= H + 1) ? m_sel : 9'h000;
      chk("play1", play1, drv && !m_turn);
      chk("play2", play2, drv && m_turn);
      chk("button", button, e_btn);
      chk("turn", turn, m_turn);
      chk("busy", busy, m_phase != 0);
      chk("reject", reject, m_rej);
      chk("excl", play1 & play2, 0);
      saw_rej = saw_rej | reject;
      saw_p1  = saw_p1 | play1;
      saw_p2  = saw_p2 | play2;
      btn_or  = btn_or | button;
      if ((play1 | play2) && !prev_drv) nplay++;
      prev_drv = play1 | play2;
   endtask

   task automatic cyc(input int k);
      repeat (k) tick();
   endtask

   task automatic clr();
      saw_rej = 0;
      saw_p1  = 0;
      saw_p2  = 0;
      btn_or  = '0;
      nplay   = 0;
   endtask

   task automatic press(input logic [8:0] m, input int hold);
      raw_btn = raw_btn | m;
      cyc(hold);
      raw_btn = raw_btn & ~m;
      cyc(D + 8);
   endtask

   task automatic pulse_ng();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
   endtask

   initial begin
      int lat;
      bit ok;
      prev_drv = 0;
      clr();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", {play1, play2, button, turn, busy, reject}, 0);
      reset = 1'b1;

      // Clean press of cell 1, measuring latency directly
      clr();
      raw_btn[8] = 1'b1;
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (play1) begin
            lat = i;
            break;
         end
      end
      chk("lat_play1", lat, D + 3);
      chk("arm_btn", button, 0);
      tick();
      chk("drv_btn", button, 9'h100);
      cyc(H + 2);
      raw_btn = '0;
      cyc(D + 8);
      chk("turn_p2", turn, 1);

      // Bounce on cell 2, then a solid hold
      clr();
      for (int i = 0; i < 12; i++) begin
         raw_btn[7] = ~raw_btn[7];
         cyc(5);
      end
      chk("bounce_quiet", {saw_p1, saw_p2, saw_rej}, 0);
      raw_btn[7] = 1'b1;
      cyc(D + 12);
      raw_btn[7] = 1'b0;
      cyc(D + 8);
      chk("bounce_p2", saw_p2, 1);
      chk("bounce_btn", btn_or, 9'h080);

      // Double press and occupied cell
      clr();
      press(9'h042, D + 6);
      chk("dbl_rej", saw_rej, 1);
      chk("dbl_noplay", saw_p1 | saw_p2, 0);
      chk("dbl_turn", turn, 0);
      clr();
      press(9'h100, D + 6);
      chk("occ_rej", saw_rej, 1);
      chk("occ_noplay", saw_p1 | saw_p2, 0);

      // Second press landing while busy
      clr();
      raw_btn[4] = 1'b1;
      cyc(2);
      raw_btn[5] = 1'b1;
      cyc(D + 12);
      raw_btn = '0;
      cyc(D + 8);
      chk("busy_rej", saw_rej, 1);
      chk("busy_btn", btn_or, 9'h010);
      chk("busy_moves", nplay, 1);

      // new_game during DRIVE
      raw_btn[0] = 1'b1;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (button != 0) begin
            ok = 1;
            break;
         end
      end
      chk("ng_reach", ok, 1);
      pulse_ng();
      chk("ng_out", {play1, play2, button, busy}, 0);
      chk("ng_turn", turn, 0);
      raw_btn = '0;
      cyc(D + 8);
      clr();
      press(9'h100, D + 6);
      chk("ng_p1", {saw_p1, saw_p2, saw_rej}, 3'b100);

      // Fill the board, then any press is refused
      pulse_ng();
      for (int c = 8; c >= 0; c--) press(9'(1 << c), D + 6);
      clr();
      press(9'h008, D + 6);
      chk("full_rej", saw_rej, 1);
      chk("full_noplay", saw_p1 | saw_p2, 0);

      // Asynchronous reset while in ARM
      pulse_ng();
      raw_btn[8] = 1'b1;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (play1) begin
            ok = 1;
            break;
         end
      end
      chk("arm_reach", ok, 1);
      #2 reset = 1'b0;
      #1;
      chk("rst_async", {play1, play2, button, busy, reject, turn}, 0);
      @(posedge clk);
      #1 raw_btn = '0;
      @(posedge clk);
      #1;
      model_reset();
      prev_drv = 0;
      reset = 1'b1;

      // Random presses, glitches, double presses and new_game pulses
      for (int k = 0; k < 150; k++) begin
         int r;
         logic [8:0] m;
         r = $urandom_range(0, 11);
         if (r == 0) begin
            pulse_ng();
         end else begin
            m = 9'(1 << $urandom_range(0, 8));
            if (r == 1) m = m | 9'(1 << $urandom_range(0, 8));
            if (r == 2) press(m, $urandom_range(1, D - 1));
            else press(m, $urandom_range(D + 2, D + 12));
         end
         cyc($urandom_range(0, 10));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tttg_input_ctrl.md
# tttg_input_ctrl

Front-end stage for the tic-tac-toe game core (`tttg`). It conditions the nine raw board push-buttons, handles turn alternation and occupied-cell filtering, and produces clean `play1`/`play2` and one-hot `button[8:0]` strobes. The strobes follow the sequence the core expects: player select first, then cell select, then all inputs released. Its outputs connect directly to the game core's `play1`, `play2` and `button` inputs.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized samples needed to accept a level change.
- `HOLD_CYCLES`, 4: cycles that `playX` and `button` are held together in DRIVE. Must be ≥1.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `raw_btn` in 9: asynchronous raw buttons, active-high. Bit 8 is cell 1 (top-left) and bit 0 is cell 9.
- `new_game` in 1: synchronous one-cycle pulse that clears the occupied mask and sets the turn to player 1.
- `play1` out 1: player-1 select to the core.
- `play2` out 1: player-2 select to the core.
- `button` out 9: one-hot cell select to the core.
- `turn` out 1: player whose move is next (0 = P1, 1 = P2).
- `busy` out 1: high whenever the FSM is not in IDLE.
- `reject` out 1: one-cycle pulse when a press is discarded.

## Operation
- **Per-bit input path:** 2-flop synchronizer, then debouncer. The debouncer counter is `$clog2(DEBOUNCE_CYCLES+1)` bits and saturates.
  - The counter reloads to 0 whenever the synchronized sample equals the current stable level.
  - The stable level flips after `DEBOUNCE_CYCLES` consecutive differing samples.
  - A stable 0→1 transition is a press event (one cycle). Releases generate no event.
- **Acceptance (evaluated in IDLE only):**
  - A press is accepted when exactly one event is present, that cell's `occupied` bit is 0, and `new_game` is low.
  - More than one simultaneous event, or an event on an occupied cell, gives `reject`=1 for one cycle and no move.
  - Any event while `busy`=1 gives `reject` and is dropped. Events are never queued.
- **FSM states:** IDLE, ARM, DRIVE, RELEASE.
  - IDLE→ARM on acceptance. The cell is latched into `sel[8:0]`.
  - ARM (1 cycle): `play1`=~`turn` and `play2`=`turn`; `button`=0.
  - DRIVE (`HOLD_CYCLES` cycles): the `playX` level is held and `button`=`sel`.
  - RELEASE (1 cycle): all outputs to the core are 0. Set `occupied |= sel` and toggle `turn`. Then go to IDLE.
- **Invariants:** `play1` and `play2` are never high together. `button` is never non-zero outside DRIVE.
- **`new_game` handling:**
  - In any state, `new_game` forces IDLE on the next edge, clears `occupied` and `sel`, sets `turn`=0, and drops all outputs to the core to 0.
  - `new_game` has priority over a coincident press. That press is dropped without `reject`.
- **Full board:** when `occupied`=9'h1FF every event is rejected until `new_game`.

## Timing
- **Reset values:** `play1`=0, `play2`=0, `button`=0, `turn`=0, `busy`=0, `reject`=0. Also: `occupied`=0, FSM=IDLE, synchronizer flops 0, stable levels 0, counters 0.
- **Press latency (clean edge):** `raw_btn[i]` rising before edge E puts `playX` high from edge E+`DEBOUNCE_CYCLES`+3 (2 sync + `DEBOUNCE_CYCLES` + 1 FSM).
- **Sequence after acceptance:**
  - `button` rises exactly 1 cycle after `playX`.
  - Both fall together after `HOLD_CYCLES` cycles.
  - `busy` spans ARM through RELEASE inclusive: `HOLD_CYCLES`+2 cycles.
- **Turn update:** `turn` updates on the edge leaving RELEASE and is valid when `busy` falls.
- **Bounce:** a glitch shorter than `DEBOUNCE_CYCLES` samples produces no event and no `reject`.
- **Reset mid-move:** reset asserted mid-move clears all outputs immediately (asynchronous). On deassertion the block resumes in IDLE. Deassertion is synchronized externally.
- **`reject` timing:** `reject` is registered and asserted the cycle after the offending event.

## Structure
- Package `tttg_pkg` holds:
  - the state enum `{IDLE, ARM, DRIVE, RELEASE}`;
  - player constants `P1`=1'b0 and `P2`=1'b1;
  - `N_CELLS`=9.
- Sub-module `tttg_debounce` (single bit: synchronizer, counter, stable level, press pulse), instantiated 9 times via generate.
- The top level contains acceptance logic, the FSM, the hold counter (`$clog2(HOLD_CYCLES+1)` bits), `sel`, `occupied` and `turn`.

## Test plan
- **Clean single press:** reset, then a clean press of bit 8.
  - `play1` high at `DEBOUNCE_CYCLES`+3.
  - `button`=9'h100 one cycle later, held 4 cycles, then all 0.
  - `turn`→1.
- **Bounce rejection:** bit 7 toggled every 5 cycles for 60 cycles, then held high. No output until held for 16 samples, then `play2` with `button`=9'h080.
- **Bad presses:**
  - Bits 6 and 1 rising together: `reject` pulse, no `playX`, `turn` unchanged.
  - Re-press of occupied bit 8: `reject`.
- **Press while busy:** press bit 5 during DRIVE of a bit-4 move. `reject` pulses, only 9'h010 is driven, and no second move follows.
- **`new_game` mid-move:** `new_game` asserted during DRIVE. Outputs go to 0 next cycle, `turn`=0, `occupied`=0, and a bit-8 press is accepted again as P1.
- **Full board and reset:**
  - After nine alternating moves, any press gives `reject`.
  - Asynchronous reset mid-ARM zeroes all outputs within the same cycle.
